// File: rtl/rand_gen.sv
// rand_gen: Fibonacci LFSR sample generator with req / rnd_valid handshake.
// Optional build macro RAND_RANGE_EN adds range_max and a mod-reduction (REDUCE) stage.
module rand_gen #(
    parameter int               WIDTH             = 16,
    parameter int               SHIFTS_PER_SAMPLE = 8,
    parameter logic [WIDTH-1:0] SEED              = {WIDTH{1'b1}}
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             req,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_in,
`ifdef RAND_RANGE_EN
    input  logic [WIDTH-1:0] range_max,
`endif
    output logic [WIDTH-1:0] rnd,
    output logic             rnd_valid,
    output logic             busy
);

`ifdef RAND_RANGE_EN
    typedef enum logic [1:0] {IDLE, SHIFT, DONE, REDUCE} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    // Tap masks, bit n-1 set for 1-based tap n.
    localparam logic [31:0] TAP32 = (WIDTH == 8)  ? 32'h0000_00B8 :
                                    (WIDTH == 16) ? 32'h0000_D008 :
                                    (WIDTH == 24) ? 32'h00E1_0000 :
                                                    32'h8020_0003;
    localparam logic [WIDTH-1:0] TAPS = TAP32[WIDTH-1:0];

    state_t           r_state;
    logic [7:0]       r_cnt;
    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_rnd;
    logic             r_valid;

    state_t           w_state_nxt;
    logic [7:0]       w_cnt_nxt;
    logic [WIDTH-1:0] w_lfsr_nxt;
    logic [WIDTH-1:0] w_rnd_nxt;
    logic             w_valid_nxt;
    logic [WIDTH-1:0] w_lfsr_step;
    logic [WIDTH-1:0] w_seed_safe;

`ifdef RAND_RANGE_EN
    logic [WIDTH-1:0] r_range;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] w_range_nxt;
    logic [WIDTH-1:0] w_div_nxt;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_dvsr;
    logic [WIDTH:0]   w_diff;

    // One restoring step: bring in the next dividend bit, subtract if it fits.
    // The remainder stays below the divisor (<= 2^WIDTH), so WIDTH bits hold it.
    assign w_trial = {r_rem, r_div[WIDTH-1]};
    assign w_dvsr  = {1'b0, r_range} + {{WIDTH{1'b0}}, 1'b1};
    assign w_diff  = w_trial - w_dvsr;
`endif

    assign w_lfsr_step = {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
    assign w_seed_safe = (seed_in == '0) ? SEED : seed_in;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_lfsr_nxt  = r_lfsr;
        w_rnd_nxt   = r_rnd;
        w_valid_nxt = 1'b0;
`ifdef RAND_RANGE_EN
        w_range_nxt = r_range;
        w_div_nxt   = r_div;
        w_rem_nxt   = r_rem;
`endif
        if (seed_load) begin
            w_lfsr_nxt  = w_seed_safe;
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req) begin
                        w_cnt_nxt   = 8'(SHIFTS_PER_SAMPLE);
                        w_state_nxt = SHIFT;
`ifdef RAND_RANGE_EN
                        w_range_nxt = range_max;
`endif
                    end
                end
                SHIFT: begin
                    if (enable) begin
                        w_lfsr_nxt = w_lfsr_step;
                        w_cnt_nxt  = r_cnt - 8'd1;
                        if (r_cnt == 8'd1) begin
`ifdef RAND_RANGE_EN
                            w_state_nxt = REDUCE;
                            w_cnt_nxt   = 8'(WIDTH);
                            w_div_nxt   = w_lfsr_step;
                            w_rem_nxt   = '0;
`else
                            w_state_nxt = DONE;
`endif
                        end
                    end
                end
`ifdef RAND_RANGE_EN
                REDUCE: begin
                    w_rem_nxt = (w_trial >= w_dvsr) ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    w_div_nxt = {r_div[WIDTH-2:0], 1'b0};
                    w_cnt_nxt = r_cnt - 8'd1;
                    if (r_cnt == 8'd1) w_state_nxt = DONE;
                end
`endif
                DONE: begin
`ifdef RAND_RANGE_EN
                    w_rnd_nxt = r_rem;
`else
                    w_rnd_nxt = r_lfsr;
`endif
                    w_valid_nxt = 1'b1;
                    w_state_nxt = IDLE;
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_lfsr  <= SEED;
            r_rnd   <= '0;
            r_valid <= 1'b0;
`ifdef RAND_RANGE_EN
            r_range <= '0;
            r_div   <= '0;
            r_rem   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_lfsr  <= w_lfsr_nxt;
            r_rnd   <= w_rnd_nxt;
            r_valid <= w_valid_nxt;
`ifdef RAND_RANGE_EN
            r_range <= w_range_nxt;
            r_div   <= w_div_nxt;
            r_rem   <= w_rem_nxt;
`endif
        end
    end

    assign rnd       = r_rnd;
    assign rnd_valid = r_valid;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_rand_gen.sv
// Self-checking bench for rand_gen (WIDTH=8, SEED=8'h0F, SHIFTS_PER_SAMPLE=3).
// Builds with or without RAND_RANGE_EN; expected values come from a sample-level model.
module tb_rand_gen;
    localparam int          W    = 8;
    localparam int          SPS  = 3;
    localparam logic [7:0]  SEED = 8'h0F;
`ifdef RAND_RANGE_EN
    localparam int          LAT  = SPS + W + 1;
`else
    localparam int          LAT  = SPS + 1;
`endif

    logic       clock = 1'b0;
    logic       reset, enable, req, seed_load, rnd_valid, busy;
    logic [7:0] seed_in, rnd;
`ifdef RAND_RANGE_EN
    logic [7:0] range_max;
`endif

    int         checks, failures;
    logic [7:0] m_lfsr, m_rnd;

    rand_gen #(.WIDTH(W), .SHIFTS_PER_SAMPLE(SPS), .SEED(SEED)) dut (
        .clock(clock), .reset(reset), .enable(enable), .req(req),
        .seed_load(seed_load), .seed_in(seed_in),
`ifdef RAND_RANGE_EN
        .range_max(range_max),
`endif
        .rnd(rnd), .rnd_valid(rnd_valid), .busy(busy)
    );

    always #5 clock = ~clock;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    // n steps of the 8-bit LFSR, taps 8,6,5,4, feedback entering bit 0.
    function automatic logic [7:0] lfsr_adv(input logic [7:0] v, input int n);
        logic [7:0] x;
        x = v;
        for (int i = 0; i < n; i++) x = {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
        return x;
    endfunction

    function automatic logic [7:0] reduce_model(input logic [7:0] v);
`ifdef RAND_RANGE_EN
        logic [8:0] num, den;
        num = {1'b0, v};
        den = {1'b0, range_max} + 9'd1;
        return 8'(num % den);
`else
        return v;
`endif
    endfunction

    task automatic test_reset;
        reset = 1'b1; enable = 1'b1; req = 1'b1; seed_load = 1'b1; seed_in = 8'hA5;
        tick; tick;
        checks++; if (rnd !== 8'h00) begin failures++; $display("FAIL reset_rnd: got %h expected 00", rnd); end
        checks++; if (rnd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", rnd_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (dut.r_lfsr !== SEED) begin failures++; $display("FAIL reset_lfsr: got %h expected %h", dut.r_lfsr, SEED); end
        reset = 1'b0; req = 1'b0; seed_load = 1'b0; seed_in = 8'h00;
        m_lfsr = SEED; m_rnd = 8'h00;
    endtask

    task automatic test_basic;
        logic [7:0] exp;
        int ns, sk;
        reset = 1'b1; tick; reset = 1'b0;
        exp = reduce_model(lfsr_adv(SEED, SPS));
        req = 1'b1; enable = 1'b1; tick; req = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", busy); end
        ns = 0; sk = -1;
        for (int k = 1; k <= LAT + 3; k++) begin
            tick;
            if (k == 1) begin checks++; if (dut.r_lfsr !== 8'h1F) begin failures++; $display("FAIL basic_lfsr1: got %h expected 1f", dut.r_lfsr); end end
            if (k == 2) begin checks++; if (dut.r_lfsr !== 8'h3E) begin failures++; $display("FAIL basic_lfsr2: got %h expected 3e", dut.r_lfsr); end end
            if (k == 3) begin checks++; if (dut.r_lfsr !== 8'h7D) begin failures++; $display("FAIL basic_lfsr3: got %h expected 7d", dut.r_lfsr); end end
            if (rnd_valid === 1'b1) begin ns++; if (sk < 0) sk = k; end
            if (k == LAT) begin checks++; if (rnd !== exp) begin failures++; $display("FAIL basic_rnd: got %h expected %h", rnd, exp); end end
        end
        checks++; if (ns != 1 || sk != LAT) begin failures++; $display("FAIL basic_strobe: got count %0d cycle %0d expected count 1 cycle %0d", ns, sk, LAT); end
        checks++; if (rnd !== exp) begin failures++; $display("FAIL basic_hold: got %h expected %h", rnd, exp); end
        m_lfsr = lfsr_adv(SEED, SPS); m_rnd = exp;
    endtask

    task automatic test_stall;
        logic [7:0] exp;
        int ns, sk;
        reset = 1'b1; tick; reset = 1'b0;
        exp = reduce_model(lfsr_adv(SEED, SPS));
        req = 1'b1; enable = 1'b1; tick; req = 1'b0;
        ns = 0; sk = -1;
        for (int k = 1; k <= LAT + 5; k++) begin
            enable = !(k == 2 || k == 3);
            tick;
            if (k == 3) begin checks++; if (dut.r_lfsr !== 8'h1F) begin failures++; $display("FAIL stall_hold: got %h expected 1f", dut.r_lfsr); end end
            if (rnd_valid === 1'b1) begin ns++; if (sk < 0) sk = k; end
        end
        enable = 1'b1;
        checks++; if (ns != 1 || sk != LAT + 2) begin failures++; $display("FAIL stall_strobe: got count %0d cycle %0d expected count 1 cycle %0d", ns, sk, LAT + 2); end
        checks++; if (rnd !== exp) begin failures++; $display("FAIL stall_rnd: got %h expected %h", rnd, exp); end
        m_lfsr = lfsr_adv(SEED, SPS); m_rnd = exp;
    endtask

    task automatic test_seed_load;
        logic [7:0] s;
        int ns;
        enable = 1'b1; req = 1'b1; tick; req = 1'b0; tick;
        seed_load = 1'b1; seed_in = 8'h00; tick; seed_load = 1'b0;
        checks++; if (dut.r_lfsr !== SEED) begin failures++; $display("FAIL seed0_lfsr: got %h expected %h", dut.r_lfsr, SEED); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL seed_busy: got %b expected 0", busy); end
        checks++; if (rnd_valid !== 1'b0) begin failures++; $display("FAIL seed_valid: got %b expected 0", rnd_valid); end
        checks++; if (rnd !== m_rnd) begin failures++; $display("FAIL seed_rnd: got %h expected %h", rnd, m_rnd); end
        m_lfsr = SEED; ns = 0;
        for (int k = 0; k < LAT + 2; k++) begin tick; if (rnd_valid === 1'b1) ns++; end
        checks++; if (ns != 0) begin failures++; $display("FAIL seed_abort: got %0d strobes expected 0", ns); end
        checks++; if (dut.r_lfsr !== m_lfsr) begin failures++; $display("FAIL idle_noshift: got %h expected %h", dut.r_lfsr, m_lfsr); end
        s = 8'($urandom_range(1, 255));
        seed_load = 1'b1; seed_in = s; req = 1'b1; tick; seed_load = 1'b0; req = 1'b0;
        checks++; if (dut.r_lfsr !== s) begin failures++; $display("FAIL seed_lfsr: got %h expected %h", dut.r_lfsr, s); end
        tick; tick;
        checks++; if (busy !== 1'b0 || rnd_valid !== 1'b0) begin failures++; $display("FAIL seed_req_drop: got busy %b valid %b expected 0 0", busy, rnd_valid); end
        m_lfsr = s;
    endtask

    task automatic test_back_to_back;
        logic [7:0] e1, e2;
        int ns, sk;
        enable = 1'b1;
        e1 = reduce_model(lfsr_adv(m_lfsr, SPS));
        req = 1'b1; tick; req = 1'b0;
        ns = 0; sk = -1;
        for (int k = 1; k <= LAT; k++) begin
            req = (k == 2 || k == LAT);
            tick; req = 1'b0;
            if (rnd_valid === 1'b1) begin ns++; if (sk < 0) sk = k; end
        end
        checks++; if (ns != 1 || sk != LAT) begin failures++; $display("FAIL b2b_first_strobe: got count %0d cycle %0d expected count 1 cycle %0d", ns, sk, LAT); end
        checks++; if (rnd !== e1) begin failures++; $display("FAIL b2b_first_rnd: got %h expected %h", rnd, e1); end
        m_lfsr = lfsr_adv(m_lfsr, SPS);
        e2 = reduce_model(lfsr_adv(m_lfsr, SPS));
        req = 1'b1; tick; req = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_accept: got busy %b expected 1", busy); end
        ns = 0; sk = -1;
        for (int k = 1; k <= LAT + 3; k++) begin
            tick;
            if (rnd_valid === 1'b1) begin ns++; if (sk < 0) sk = k; end
        end
        checks++; if (ns != 1 || sk != LAT) begin failures++; $display("FAIL b2b_second_strobe: got count %0d cycle %0d expected count 1 cycle %0d", ns, sk, LAT); end
        checks++; if (rnd !== e2) begin failures++; $display("FAIL b2b_second_rnd: got %h expected %h", rnd, e2); end
        m_lfsr = lfsr_adv(m_lfsr, SPS); m_rnd = e2;
    endtask

    task automatic test_reset_mid;
        int ns;
        enable = 1'b1; req = 1'b1; tick; req = 1'b0; tick; tick;
        reset = 1'b1; tick; reset = 1'b0;
        checks++; if (rnd !== 8'h00 || rnd_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_out: got rnd %h valid %b busy %b expected 00 0 0", rnd, rnd_valid, busy); end
        checks++; if (dut.r_lfsr !== SEED) begin failures++; $display("FAIL rstmid_lfsr: got %h expected %h", dut.r_lfsr, SEED); end
        ns = 0;
        for (int k = 0; k < LAT + 2; k++) begin tick; if (rnd_valid === 1'b1) ns++; end
        checks++; if (ns != 0) begin failures++; $display("FAIL rstmid_nostrobe: got %0d strobes expected 0", ns); end
        m_lfsr = SEED; m_rnd = 8'h00;
    endtask

    task automatic test_random;
        logic [7:0] s, exp;
        int e, exp_k, got_k, zero_seen;
        logic en;
        zero_seen = 0;
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                s = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
                seed_load = 1'b1; seed_in = s; tick; seed_load = 1'b0;
                m_lfsr = (s == 8'h00) ? SEED : s;
            end
`ifdef RAND_RANGE_EN
            case ($urandom_range(0, 5))
                0:       range_max = 8'h00;
                1:       range_max = 8'hFF;
                default: range_max = 8'($urandom_range(0, 255));
            endcase
`endif
            exp = reduce_model(lfsr_adv(m_lfsr, SPS));
            req = 1'b1; enable = 1'($urandom_range(0, 1)); tick; req = 1'b0;
`ifdef RAND_RANGE_EN
            range_max = ~range_max;
`endif
            e = 0; exp_k = -1; got_k = -1;
            for (int k = 1; k <= 200 && got_k < 0; k++) begin
                en = ($urandom_range(0, 3) != 0);
                enable = en;
                req = ($urandom_range(0, 7) == 0);
                tick; req = 1'b0;
                if (en && e < SPS) begin
                    e++;
                    if (e == SPS) exp_k = k + LAT - SPS;
                end
                if (dut.r_lfsr === 8'h00) zero_seen++;
                if (rnd_valid === 1'b1) got_k = k;
            end
            checks++; if (got_k != exp_k) begin failures++; $display("FAIL rand_latency[%0d]: got cycle %0d expected %0d", it, got_k, exp_k); end
            checks++; if (rnd !== exp) begin failures++; $display("FAIL rand_rnd[%0d]: got %h expected %h", it, rnd, exp); end
            m_lfsr = lfsr_adv(m_lfsr, SPS); m_rnd = exp;
        end
        checks++; if (zero_seen != 0) begin failures++; $display("FAIL rand_lockup: got %0d zero-state cycles expected 0", zero_seen); end
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b0; enable = 1'b0; req = 1'b0; seed_load = 1'b0; seed_in = 8'h00;
`ifdef RAND_RANGE_EN
        range_max = 8'd9;
`endif
        test_reset;
`ifdef RAND_RANGE_EN
        range_max = 8'd9;  test_basic;
        range_max = 8'hFF; test_basic;
        range_max = 8'h00; test_basic;
        range_max = 8'd37;
`else
        test_basic;
`endif
        test_stall;
        test_seed_load;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rand_gen.md
RAND_GEN -- requirements
Module: rand_gen

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning the LFSR and output width; legal values are 8, 16, 24 and 32.
REQ-002 The module SHALL have parameter SHIFTS_PER_SAMPLE, default 8, meaning the LFSR shifts per delivered sample; legal range is 1..255.
REQ-003 The module SHALL have parameter SEED, default {WIDTH{1'b1}}, meaning the reset and lockup-recovery value; it must be nonzero.
REQ-004 The module SHALL have port clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port enable, input, 1 bit: shift-advance qualifier.
REQ-007 The module SHALL have port req, input, 1 bit: sample request.
REQ-008 The module SHALL have port seed_load, input, 1 bit: load seed_in into the LFSR.
REQ-009 The module SHALL have port seed_in, input, WIDTH bits: seed value.
REQ-010 The module SHALL have port rnd, output, WIDTH bits: last delivered sample.
REQ-011 The module SHALL have port rnd_valid, output, 1 bit: one-cycle strobe marking a new rnd.
REQ-012 The module SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-013 The LFSR SHALL be Fibonacci, shift left, feedback = XOR of taps inserted at bit 0.
REQ-014 The taps (1-based) SHALL be: WIDTH 8 -> 8,6,5,4; 16 -> 16,15,13,4; 24 -> 24,23,22,17; 32 -> 32,22,2,1.
REQ-015 The FSM SHALL have states IDLE, SHIFT and DONE, plus REDUCE when RAND_RANGE_EN is defined.
REQ-016 In IDLE with req=1, the FSM SHALL load shift counter = SHIFTS_PER_SAMPLE and move to SHIFT; req outside IDLE SHALL be ignored (no queuing).
REQ-017 In SHIFT, each cycle with enable=1 SHALL shift the LFSR once and decrement the counter; enable=0 SHALL hold LFSR and counter.
REQ-018 On the shift that brings the counter to 0, the FSM SHALL go to DONE (or to REDUCE when RAND_RANGE_EN is defined).
REQ-019 In DONE, the block SHALL register rnd = LFSR value, assert rnd_valid for exactly that cycle, and return to IDLE.
REQ-020 With enable held high, rnd_valid SHALL assert exactly SHIFTS_PER_SAMPLE+1 cycles after the req-accept edge.
REQ-021 rnd SHALL hold its value between strobes; the LFSR SHALL NOT shift in IDLE.
REQ-022 seed_load SHALL have priority over all other activity in any state: LFSR <= seed_in, FSM -> IDLE, in-flight sample aborted with no rnd_valid, rnd unchanged.
REQ-023 Lockup guard: an all-zero seed_in SHALL load SEED instead; the LFSR SHALL never hold zero.
REQ-024 seed_load and req in the same cycle: the seed SHALL be loaded and req SHALL be dropped.

Reset
REQ-025 When reset=1 at a clock edge, the block SHALL set LFSR = SEED, FSM = IDLE, counter = 0, rnd = 0, rnd_valid = 0 and busy = 0.
REQ-026 Reset SHALL override seed_load and req, and SHALL abort any in-flight sample with no strobe.

Configuration
REQ-027 When macro RAND_RANGE_EN is defined, the block SHALL add input range_max[WIDTH], which is sampled on the req-accept edge.
REQ-028 With RAND_RANGE_EN defined, the REDUCE state SHALL compute the LFSR sample mod (range_max+1) by restoring shift-subtract in exactly WIDTH cycles, then go to DONE.
REQ-029 With RAND_RANGE_EN defined, DONE SHALL deliver the reduced value, giving a latency of SHIFTS_PER_SAMPLE+WIDTH+1 cycles.
REQ-030 With RAND_RANGE_EN defined, range_max all-ones SHALL pass the value unchanged with the same latency, and range_max=0 SHALL yield 0.
REQ-031 With RAND_RANGE_EN defined, enable SHALL NOT stall REDUCE, and seed_load SHALL abort REDUCE.
REQ-032 When RAND_RANGE_EN is not defined, the range_max port and the REDUCE state SHALL be absent.

Verification
REQ-033 The bench SHALL cover: WIDTH=8, SEED=8'h0F, SHIFTS_PER_SAMPLE=3, enable=1, req at cycle 0 -> rnd=8'h7D with rnd_valid high at cycle 4 only; intermediate LFSR values 8'h1F, 8'h3E.
REQ-034 The bench SHALL cover: the REQ-033 run with enable low for 2 cycles mid-SHIFT -> same rnd=8'h7D, strobe at cycle 6.
REQ-035 The bench SHALL cover: seed_load=1 with seed_in=0 during SHIFT -> LFSR=SEED, busy falls next cycle, no rnd_valid, rnd unchanged.
REQ-036 The bench SHALL cover: req pulsed again while busy -> ignored, exactly one strobe; back-to-back req after DONE -> second sample continues from the current LFSR state.
REQ-037 The bench SHALL cover: RAND_RANGE_EN defined, the REQ-033 setup, range_max=9 -> rnd=5 at cycle 12; range_max=8'hFF -> rnd=8'h7D at cycle 12.
REQ-038 The bench SHALL cover: reset asserted mid-SHIFT -> next cycle all outputs 0, LFSR=SEED, no strobe.
